// File: rtl/conv_frame_sequencer_if.sv
// Bus bundle between the frame sequencer, the pixel memory read port and conv_buffer.
// The master side is the sequencer; the slave side is the memory/buffer environment.
interface conv_frame_sequencer_if #(
   parameter int DATA_WIDTH = 8,
   parameter int LW         = 11,
   parameter int ADDR_WIDTH = 22
);
   logic                  mem_rd_en;
   logic [ADDR_WIDTH-1:0] mem_rd_addr;
   logic [DATA_WIDTH-1:0] mem_rd_data;
   logic                  buf_valid_in;
   logic [DATA_WIDTH-1:0] buf_in_point;
   logic [LW-1:0]         buf_frame_column_size;
   logic [LW-1:0]         buf_frame_row_size;
   logic                  buf_valid_out;

   modport master (
      output mem_rd_en, mem_rd_addr,
      input  mem_rd_data,
      output buf_valid_in, buf_in_point, buf_frame_column_size, buf_frame_row_size,
      input  buf_valid_out
   );

   modport slave (
      input  mem_rd_en, mem_rd_addr,
      output mem_rd_data,
      input  buf_valid_in, buf_in_point, buf_frame_column_size, buf_frame_row_size,
      output buf_valid_out
   );
endinterface

// File: rtl/conv_frame_sequencer.sv
// Streams one raster-order frame from pixel memory into conv_buffer, waits for the
// buffer's tail windows, counts emitted windows and signals completion.
module conv_frame_sequencer #(
   parameter int DATA_WIDTH    = 8,
   parameter int BUFFER_LENGTH = 2000,
   parameter int ADDR_WIDTH    = 22,
   parameter int DRAIN_CYCLES  = 3,
   localparam int LW           = $clog2(BUFFER_LENGTH)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [LW-1:0]          cfg_cols,
   input  logic [LW-1:0]          cfg_rows,
   input  logic [ADDR_WIDTH-1:0]  cfg_base_addr,
   input  logic                   stall,
   conv_frame_sequencer_if.master bus,
   output logic                   busy,
   output logic                   done,
   output logic                   cfg_err,
   output logic [2*LW-1:0]        window_count
);

   localparam int DW = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;

   localparam logic [2*LW-1:0]       IDX_ZERO   = {(2*LW){1'b0}};
   localparam logic [2*LW-1:0]       IDX_ONE    = {{(2*LW-1){1'b0}}, 1'b1};
   localparam logic [2*LW-1:0]       WC_MAX     = {(2*LW){1'b1}};
   localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO  = {ADDR_WIDTH{1'b0}};
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [LW-1:0]         LW_ZERO    = {LW{1'b0}};
   localparam logic [LW-1:0]         LW_TWO     = LW'(2);
   localparam logic [DW-1:0]         DRAIN_ZERO = {DW{1'b0}};
   localparam logic [DW-1:0]         DRAIN_ONE  = {{(DW-1){1'b0}}, 1'b1};
   localparam logic [DW-1:0]         DRAIN_LAST = DW'(DRAIN_CYCLES);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_DRAIN  = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   state_t                state_r;
   logic [LW-1:0]         cols_r;
   logic [LW-1:0]         rows_r;
   logic [ADDR_WIDTH-1:0] addr_r;
   logic [2*LW-1:0]       idx_r;
   logic [2*LW-1:0]       last_idx_r;
   logic [DW-1:0]         drain_cnt_r;
   logic                  cfg_err_r;
   logic                  valid_in_r;
   logic [2*LW-1:0]       window_count_r;
   logic                  rd_fire_s;
   logic                  frame_ok_s;
   logic [2*LW-1:0]       last_idx_s;

   assign frame_ok_s = (cfg_cols >= LW_TWO) && (cfg_rows >= LW_TWO);
   assign last_idx_s = ((2*LW)'(cfg_cols) * (2*LW)'(cfg_rows)) - IDX_ONE;

   // A read issues in every unstalled STREAM cycle; stall acts in the same cycle.
   always_comb begin
      rd_fire_s = 1'b0;
      if ((state_r == ST_STREAM) && !stall) begin
         rd_fire_s = 1'b1;
      end else begin
         rd_fire_s = 1'b0;
      end
   end

   // Frame control FSM: latch geometry, walk the pixel index, drain, report.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         cols_r      <= LW_ZERO;
         rows_r      <= LW_ZERO;
         addr_r      <= ADDR_ZERO;
         idx_r       <= IDX_ZERO;
         last_idx_r  <= IDX_ZERO;
         drain_cnt_r <= DRAIN_ZERO;
         cfg_err_r   <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  cols_r      <= cfg_cols;
                  rows_r      <= cfg_rows;
                  addr_r      <= cfg_base_addr;
                  idx_r       <= IDX_ZERO;
                  last_idx_r  <= last_idx_s;
                  drain_cnt_r <= DRAIN_ZERO;
                  if (frame_ok_s) begin
                     state_r   <= ST_STREAM;
                     cfg_err_r <= 1'b0;
                  end else begin
                     state_r   <= ST_DONE;
                     cfg_err_r <= 1'b1;
                  end
               end
            end
            ST_STREAM: begin
               // addr_r tracks base + index and wraps naturally at ADDR_WIDTH.
               if (rd_fire_s) begin
                  addr_r <= addr_r + ADDR_ONE;
                  idx_r  <= idx_r + IDX_ONE;
                  if (idx_r == last_idx_r) begin
                     state_r <= ST_DRAIN;
                  end
               end
            end
            ST_DRAIN: begin
               if (drain_cnt_r == DRAIN_LAST) begin
                  state_r <= ST_DONE;
               end else begin
                  drain_cnt_r <= drain_cnt_r + DRAIN_ONE;
               end
            end
            ST_DONE: begin
               state_r   <= ST_IDLE;
               cfg_err_r <= 1'b0;
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   // Memory data arrives one cycle after the strobe, so valid_in is the delayed strobe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_in_r <= 1'b0;
      end else begin
         valid_in_r <= rd_fire_s;
      end
   end

   // Saturating count of buffer output windows for the active or most recent frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         window_count_r <= IDX_ZERO;
      end else if ((state_r == ST_IDLE) && start) begin
         window_count_r <= IDX_ZERO;
      end else if (bus.buf_valid_out && (state_r != ST_IDLE) && (window_count_r != WC_MAX)) begin
         window_count_r <= window_count_r + IDX_ONE;
      end
   end

   assign bus.mem_rd_en             = rd_fire_s;
   assign bus.mem_rd_addr           = addr_r;
   assign bus.buf_valid_in          = valid_in_r;
   assign bus.buf_in_point          = bus.mem_rd_data;
   assign bus.buf_frame_column_size = cols_r;
   assign bus.buf_frame_row_size    = rows_r;
   assign busy                      = (state_r == ST_STREAM) || (state_r == ST_DRAIN);
   assign done                      = (state_r == ST_DONE);
   assign cfg_err                   = cfg_err_r;
   assign window_count              = window_count_r;

endmodule

// File: tb/tb_conv_frame_sequencer.sv
// Scenario bench for conv_frame_sequencer: expected read addresses and pixels are
// queued as frames are driven and checked as the DUT issues reads and valid_in.
module tb_conv_frame_sequencer;
   localparam int LW = 11;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [LW-1:0] cfg_cols = 11'd0;
   logic [LW-1:0] cfg_rows = 11'd0;
   logic [21:0]   cfg_base_addr = 22'd0;
   logic          stall = 1'b0;
   logic          busy, done, cfg_err;
   logic [2*LW-1:0] window_count;

   conv_frame_sequencer_if #(.DATA_WIDTH(8), .LW(LW), .ADDR_WIDTH(22)) bus_if ();

   conv_frame_sequencer #(.DATA_WIDTH(8), .BUFFER_LENGTH(2000), .ADDR_WIDTH(22), .DRAIN_CYCLES(3)) dut (
      .clk(clk), .rst(rst), .start(start), .cfg_cols(cfg_cols), .cfg_rows(cfg_rows),
      .cfg_base_addr(cfg_base_addr), .stall(stall), .bus(bus_if), .busy(busy), .done(done),
      .cfg_err(cfg_err), .window_count(window_count)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   logic [21:0] addr_q[$];
   logic [7:0]  pix_q[$];

   function automatic logic [7:0] pix_of(input logic [21:0] a);
      return a[7:0] ^ a[15:8] ^ {2'b00, a[21:16]} ^ 8'hA5;
   endfunction

   // pixel memory: data one cycle after the read strobe
   always @(posedge clk) begin
      if (bus_if.mem_rd_en) bus_if.mem_rd_data <= pix_of(bus_if.mem_rd_addr);
   end

   // scoreboard monitor
   initial begin
      logic [21:0] ea;
      logic [7:0]  ep;
      forever begin
         @(negedge clk);
         if (bus_if.buf_valid_in) begin
            n_cmp++;
            if (pix_q.size() == 0) begin
               n_err++;
               $display("FAIL unexpected_valid_in: got point %h required no valid_in", bus_if.buf_in_point);
            end else begin
               ep = pix_q.pop_front();
               if (bus_if.buf_in_point !== ep) begin
                  n_err++;
                  $display("FAIL in_point: got %h required %h", bus_if.buf_in_point, ep);
               end
            end
         end
         if (bus_if.mem_rd_en) begin
            n_cmp++;
            if (addr_q.size() == 0) begin
               n_err++;
               $display("FAIL unexpected_read: got addr %h required no read", bus_if.mem_rd_addr);
            end else begin
               ea = addr_q.pop_front();
               if (bus_if.mem_rd_addr !== ea) begin
                  n_err++;
                  $display("FAIL rd_addr: got %h required %h", bus_if.mem_rd_addr, ea);
               end
               pix_q.push_back(pix_of(ea));
            end
         end
      end
   end

   // per-run observations
   logic [63:0] en_mask, vin_mask;
   int          done_cnt, done_cyc, busy_first, busy_last;
   logic        err_at_done, rst_zero;
   logic [2*LW-1:0] wc_at_done;

   task automatic push_frame(input int cols, input int rows, input logic [21:0] base);
      for (int i = 0; i < cols * rows; i++) addr_q.push_back(base + 22'(i));
   endtask

   task automatic run_frame(input int cols, input int rows, input logic [21:0] base,
                            input logic [63:0] stall_m, input logic [63:0] vo_m,
                            input int restart_cyc, input int cols2, input int rows2,
                            input logic [21:0] base2, input int rst_cyc, input int n_cyc);
      en_mask = 64'd0; vin_mask = 64'd0; done_cnt = 0; done_cyc = -1;
      busy_first = -1; busy_last = -1; err_at_done = 1'b0; rst_zero = 1'b0; wc_at_done = 22'd0;
      @(posedge clk); #1;
      cfg_cols = 11'(cols); cfg_rows = 11'(rows); cfg_base_addr = base; start = 1'b1;
      for (int k = 1; k <= n_cyc; k++) begin
         @(posedge clk); #1;
         start = (k == restart_cyc);
         if (k == restart_cyc) begin
            cfg_cols = 11'(cols2); cfg_rows = 11'(rows2); cfg_base_addr = base2;
         end
         stall = stall_m[k];
         bus_if.buf_valid_out = vo_m[k];
         rst = (k == rst_cyc);
         @(negedge clk);
         if (bus_if.mem_rd_en) en_mask[k] = 1'b1;
         if (bus_if.buf_valid_in) vin_mask[k] = 1'b1;
         if (busy) begin
            if (busy_first < 0) busy_first = k;
            busy_last = k;
         end
         if (done) begin
            done_cnt++; done_cyc = k; err_at_done = cfg_err; wc_at_done = window_count;
         end
         if (k == rst_cyc)
            rst_zero = !bus_if.mem_rd_en && (bus_if.mem_rd_addr == 22'd0) && !bus_if.buf_valid_in &&
                       (bus_if.buf_frame_column_size == 11'd0) && (bus_if.buf_frame_row_size == 11'd0) &&
                       !busy && !done && !cfg_err && (window_count == 22'd0);
      end
      @(posedge clk); #1;
      start = 1'b0; stall = 1'b0; bus_if.buf_valid_out = 1'b0; rst = 1'b0;
   endtask

   function automatic logic [63:0] span(input int lo, input int hi);
      logic [63:0] m = 64'd0;
      for (int i = lo; i <= hi; i++) m[i] = 1'b1;
      return m;
   endfunction

   task automatic test_reset;
      bus_if.buf_valid_out = 1'b0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if ({bus_if.mem_rd_en, bus_if.buf_valid_in, busy, done, cfg_err} !== 5'b00000) begin
         n_err++; $display("FAIL reset_flags: got %b required 00000", {bus_if.mem_rd_en, bus_if.buf_valid_in, busy, done, cfg_err});
      end
      n_cmp++;
      if ({bus_if.mem_rd_addr, bus_if.buf_frame_column_size, bus_if.buf_frame_row_size, window_count} !== 66'd0) begin
         n_err++; $display("FAIL reset_values: got addr %h cols %0d rows %0d wc %0d required all 0",
                           bus_if.mem_rd_addr, bus_if.buf_frame_column_size, bus_if.buf_frame_row_size, window_count);
      end
      #1 rst = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({bus_if.mem_rd_en, busy, done} !== 3'b000) begin
         n_err++; $display("FAIL idle_after_reset: got %b required 000", {bus_if.mem_rd_en, busy, done});
      end
   endtask

   task automatic test_basic;
      push_frame(4, 4, 22'h100);
      run_frame(4, 4, 22'h100, 64'd0, 64'd0, 0, 0, 0, 22'd0, 0, 26);
      n_cmp++; if (en_mask !== span(1, 16)) begin n_err++; $display("FAIL basic_rd_en: got %h required %h", en_mask, span(1, 16)); end
      n_cmp++; if (vin_mask !== span(2, 17)) begin n_err++; $display("FAIL basic_valid_in: got %h required %h", vin_mask, span(2, 17)); end
      n_cmp++; if (done_cyc !== 21 || done_cnt !== 1) begin n_err++; $display("FAIL basic_done: got cycle %0d count %0d required cycle 21 count 1", done_cyc, done_cnt); end
      n_cmp++; if (err_at_done !== 1'b0) begin n_err++; $display("FAIL basic_cfg_err: got %b required 0", err_at_done); end
      n_cmp++; if (busy_first !== 1 || busy_last !== 20) begin n_err++; $display("FAIL basic_busy: got %0d..%0d required 1..20", busy_first, busy_last); end
      n_cmp++; if (bus_if.buf_frame_column_size !== 11'd4 || bus_if.buf_frame_row_size !== 11'd4) begin
         n_err++; $display("FAIL basic_size: got %0dx%0d required 4x4", bus_if.buf_frame_column_size, bus_if.buf_frame_row_size); end
      n_cmp++; if (addr_q.size() != 0 || pix_q.size() != 0) begin n_err++; $display("FAIL basic_drain_queue: got %0d/%0d left required 0/0", addr_q.size(), pix_q.size()); end
   endtask

   task automatic test_stall;
      logic [63:0] exp_en;
      exp_en = span(1, 4) | span(8, 19);
      push_frame(4, 4, 22'h100);
      run_frame(4, 4, 22'h100, span(5, 7), 64'd0, 0, 0, 0, 22'd0, 0, 28);
      n_cmp++; if (en_mask !== exp_en) begin n_err++; $display("FAIL stall_rd_en: got %h required %h", en_mask, exp_en); end
      n_cmp++; if (vin_mask !== (exp_en << 1)) begin n_err++; $display("FAIL stall_valid_in: got %h required %h", vin_mask, exp_en << 1); end
      n_cmp++; if (done_cyc !== 24) begin n_err++; $display("FAIL stall_done: got cycle %0d required 24", done_cyc); end
      n_cmp++; if (addr_q.size() != 0 || pix_q.size() != 0) begin n_err++; $display("FAIL stall_queue: got %0d/%0d left required 0/0", addr_q.size(), pix_q.size()); end
   endtask

   task automatic test_cfg_err;
      run_frame(1, 5, 22'h100, 64'd0, 64'd0, 0, 0, 0, 22'd0, 0, 8);
      n_cmp++; if (en_mask !== 64'd0) begin n_err++; $display("FAIL cfgerr_reads: got %h required 0", en_mask); end
      n_cmp++; if (done_cyc !== 1 || done_cnt !== 1 || err_at_done !== 1'b1) begin
         n_err++; $display("FAIL cfgerr_done: got cycle %0d count %0d err %b required cycle 1 count 1 err 1", done_cyc, done_cnt, err_at_done); end
      n_cmp++; if (busy_first !== -1) begin n_err++; $display("FAIL cfgerr_busy: got first busy %0d required never", busy_first); end
      n_cmp++; if (bus_if.buf_frame_column_size !== 11'd1 || bus_if.buf_frame_row_size !== 11'd5) begin
         n_err++; $display("FAIL cfgerr_latch: got %0dx%0d required 1x5", bus_if.buf_frame_column_size, bus_if.buf_frame_row_size); end
   endtask

   task automatic test_reset_mid;
      push_frame(4, 4, 22'h100);
      run_frame(4, 4, 22'h100, 64'd0, 64'd0, 0, 0, 0, 22'd0, 8, 16);
      n_cmp++; if (rst_zero !== 1'b1) begin n_err++; $display("FAIL midrst_outputs: got nonzero outputs required all 0"); end
      n_cmp++; if (done_cnt !== 0) begin n_err++; $display("FAIL midrst_done: got %0d done pulses required 0", done_cnt); end
      n_cmp++; if (busy_last !== 7 || addr_q.size() != 9) begin
         n_err++; $display("FAIL midrst_abort: got last busy %0d reads left %0d required 7 and 9", busy_last, addr_q.size()); end
      addr_q.delete();
      pix_q.delete();
      push_frame(4, 4, 22'h100);
      run_frame(4, 4, 22'h100, 64'd0, 64'd0, 0, 0, 0, 22'd0, 0, 24);
      n_cmp++; if (en_mask !== span(1, 16) || done_cyc !== 21) begin
         n_err++; $display("FAIL midrst_restart: got en %h done %0d required %h done 21", en_mask, done_cyc, span(1, 16)); end
      n_cmp++; if (addr_q.size() != 0 || pix_q.size() != 0) begin n_err++; $display("FAIL midrst_queue: got %0d/%0d left required 0/0", addr_q.size(), pix_q.size()); end
   endtask

   task automatic test_window_count;
      push_frame(4, 4, 22'h200);
      run_frame(4, 4, 22'h200, 64'd0, span(3, 11) | span(23, 25), 10, 2, 2, 22'h000, 0, 30);
      n_cmp++; if (wc_at_done !== 22'd9) begin n_err++; $display("FAIL wc_at_done: got %0d required 9", wc_at_done); end
      n_cmp++; if (window_count !== 22'd9) begin n_err++; $display("FAIL wc_idle_hold: got %0d required 9", window_count); end
      n_cmp++; if (done_cnt !== 1 || en_mask !== span(1, 16)) begin
         n_err++; $display("FAIL ignored_start: got done count %0d en %h required 1 and %h", done_cnt, en_mask, span(1, 16)); end
      n_cmp++; if (bus_if.buf_frame_column_size !== 11'd4 || bus_if.buf_frame_row_size !== 11'd4) begin
         n_err++; $display("FAIL no_relatch: got %0dx%0d required 4x4", bus_if.buf_frame_column_size, bus_if.buf_frame_row_size); end
   endtask

   task automatic test_wrap;
      push_frame(2, 2, 22'h3FFFFE);
      run_frame(2, 2, 22'h3FFFFE, 64'd0, 64'd0, 0, 0, 0, 22'd0, 0, 12);
      n_cmp++; if (done_cyc !== 9 || err_at_done !== 1'b0) begin n_err++; $display("FAIL wrap_done: got cycle %0d err %b required 9 and 0", done_cyc, err_at_done); end
      n_cmp++; if (addr_q.size() != 0 || pix_q.size() != 0) begin n_err++; $display("FAIL wrap_queue: got %0d/%0d left required 0/0", addr_q.size(), pix_q.size()); end
   endtask

   task automatic test_back_to_back;
      push_frame(2, 2, 22'h040);
      run_frame(2, 2, 22'h040, 64'd0, 64'd0, 9, 2, 3, 22'h080, 0, 14);
      n_cmp++; if (done_cnt !== 1 || en_mask !== span(1, 4)) begin
         n_err++; $display("FAIL start_in_done: got done count %0d en %h required 1 and %h", done_cnt, en_mask, span(1, 4)); end
      push_frame(2, 2, 22'h040);
      push_frame(2, 3, 22'h080);
      run_frame(2, 2, 22'h040, 64'd0, 64'd0, 10, 2, 3, 22'h080, 0, 26);
      n_cmp++; if (done_cnt !== 2 || done_cyc !== 21) begin
         n_err++; $display("FAIL b2b_done: got count %0d last %0d required 2 and 21", done_cnt, done_cyc); end
      n_cmp++; if (en_mask !== (span(1, 4) | span(11, 16))) begin
         n_err++; $display("FAIL b2b_rd_en: got %h required %h", en_mask, span(1, 4) | span(11, 16)); end
      n_cmp++; if (addr_q.size() != 0 || pix_q.size() != 0) begin n_err++; $display("FAIL b2b_queue: got %0d/%0d left required 0/0", addr_q.size(), pix_q.size()); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_cfg_err();
      test_reset_mid();
      test_window_count();
      test_wrap();
      test_back_to_back();
      repeat (3) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
